// File: rtl/cpu_ce_gen.sv
// cpu_ce_gen: CPU / PSG clock-enable generator for the clk_sys domain.
// Three selectable CPU speed modes with an enable-quiet gap at each switch,
// per-period contention stalls, and a free-running PSG enable.
// Optional build macro CE_GEN_STALL_CNT_EN adds the stall_cnt output, which
// counts RUN periods suppressed by a stall.
module cpu_ce_gen #(
    parameter int DIV0       = 16,
    parameter int DIV1       = 27,
    parameter int DIV2       = 4,
    parameter int PSG_DIV    = 12,
    parameter int SWITCH_GAP = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       wait_req,
    output logic       ce_p,
    output logic       ce_n,
    output logic       ce_psg,
    output logic [1:0] mode_cur,
    output logic       switching
`ifdef CE_GEN_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int GW = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
    localparam int PW = $clog2(PSG_DIV);
    localparam logic [GW-1:0] GAP_LAST = GW'(SWITCH_GAP - 1);
    localparam logic [PW-1:0] PSG_LAST = PW'(PSG_DIV - 1);

    typedef enum logic {RUN, GAP} state_t;

    state_t         state;
    logic [5:0]     cnt;
    logic [GW-1:0]  gap_cnt;
    logic [PW-1:0]  psg_cnt;
    logic           stall;

    logic [1:0]     req;
    logic [5:0]     div_cur;
    logic [5:0]     half;
    logic           last;

    // Divider for a given mode; mode 3 falls back to the native divider.
    function automatic logic [5:0] div_of(input logic [1:0] m);
        case (m)
            2'd1:    return 6'(DIV1);
            2'd2:    return 6'(DIV2);
            default: return 6'(DIV0);
        endcase
    endfunction

    // Effective requested mode, active divider and period-position decodes.
    always_comb begin
        req     = (mode == 2'd3) ? 2'd0 : mode;
        div_cur = div_of(mode_cur);
        half    = div_cur >> 1;
        last    = (cnt == div_cur - 6'd1);
    end

    // Period counter, stall latch and the RUN/GAP switch state machine.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= 6'd0;
            gap_cnt   <= '0;
            stall     <= 1'b0;
            mode_cur  <= 2'd0;
            switching <= 1'b0;
            ce_p      <= 1'b0;
            ce_n      <= 1'b0;
        end else begin
            ce_p <= (state == RUN) && !stall && (cnt == 6'd0);
            ce_n <= (state == RUN) && !stall && (cnt == half);
            if (last) begin
                cnt   <= 6'd0;
                stall <= wait_req;
                case (state)
                    RUN: begin
                        if (req != mode_cur) begin
                            state     <= GAP;
                            switching <= 1'b1;
                            mode_cur  <= req;
                            gap_cnt   <= '0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            if (req == mode_cur) begin
                                state     <= RUN;
                                switching <= 1'b0;
                            end else begin
                                mode_cur <= req;
                                gap_cnt  <= '0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end else begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    // Free-running PSG enable, independent of mode, stall and switching.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            psg_cnt <= '0;
            ce_psg  <= 1'b0;
        end else begin
            ce_psg  <= (psg_cnt == '0);
            psg_cnt <= (psg_cnt == PSG_LAST) ? '0 : psg_cnt + 1'b1;
        end
    end

`ifdef CE_GEN_STALL_CNT_EN
    // Count stalled RUN periods (saturating); a switch into GAP clears it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (last && (state == RUN) && (req != mode_cur)) begin
            stall_cnt <= 16'd0;
        end else if ((state == RUN) && stall && (cnt == 6'd0)
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_ce_gen.sv
// tb_cpu_ce_gen: self-checking bench for cpu_ce_gen.
// A period-level model schedules the expected enable pattern of every CPU
// period into a queue when the previous period ends; directed scenarios pin
// exact pulse positions with literal edge numbers, then a random phase runs.
module tb_cpu_ce_gen;

    localparam int DIV0       = 16;
    localparam int DIV1       = 27;
    localparam int DIV2       = 4;
    localparam int PSG_DIV    = 12;
    localparam int SWITCH_GAP = 3;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] mode    = 2'd0;
    logic       wait_req = 1'b0;
    logic       ce_p, ce_n, ce_psg, switching;
    logic [1:0] mode_cur;
`ifdef CE_GEN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    cpu_ce_gen #(
        .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2),
        .PSG_DIV(PSG_DIV), .SWITCH_GAP(SWITCH_GAP)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .mode(mode),
        .wait_req(wait_req),
        .ce_p(ce_p),
        .ce_n(ce_n),
        .ce_psg(ce_psg),
        .mode_cur(mode_cur),
        .switching(switching)
`ifdef CE_GEN_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic p;
        logic n;
        logic srun;
    } exp_t;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   edge_n       = 0;
    bit   model_on     = 0;
    exp_t exp_q[$];
    int   p_edges[$];
    int   n_edges[$];
    int   psg_edges[$];

    int   m_mode      = 0;
    int   gaps_left   = 0;
    int   m_stall_cnt = 0;

    function automatic int div_for(input int m);
        if (m == 1) return DIV1;
        if (m == 2) return DIV2;
        return DIV0;
    endfunction

    task automatic check_output(input string name, input int act, input int expv);
        n_compared++;
        if (act != expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    task automatic check_edge(input string name, input int q[$], input int idx, input int expv);
        if (idx < q.size()) check_output(name, q[idx], expv);
        else check_output(name, -1, expv);
    endtask

    // Queue one whole period of expected enables: ce_p after its first edge,
    // ce_n after edge D/2, nothing at all when gapped or stalled.
    task automatic push_period(input int m, input bit is_run, input bit stl);
        int d;
        d = div_for(m);
        for (int k = 0; k < d; k++) begin
            exp_t e;
            e.p    = is_run && !stl && (k == 0);
            e.n    = is_run && !stl && (k == d / 2);
            e.srun = is_run && stl && (k == 0);
            exp_q.push_back(e);
        end
    endtask

    // Decide the next period at a boundary from the inputs seen at that edge.
    task automatic plan_period();
        int req;
        bit stl;
        req = (mode == 2'd3) ? 0 : int'(mode);
        stl = wait_req;
        if (gaps_left == 0) begin
            if (req != m_mode) begin
                m_mode      = req;
                gaps_left   = SWITCH_GAP;
                m_stall_cnt = 0;
            end
        end else begin
            gaps_left--;
            if (gaps_left == 0 && req != m_mode) begin
                m_mode    = req;
                gaps_left = SWITCH_GAP;
            end
        end
        push_period(m_mode, gaps_left == 0, stl);
    endtask

    task automatic model_init();
        exp_q.delete();
        p_edges.delete();
        n_edges.delete();
        psg_edges.delete();
        edge_n      = 0;
        m_mode      = 0;
        gaps_left   = 0;
        m_stall_cnt = 0;
        push_period(0, 1'b1, 1'b0);
    endtask

    // Compare every output against the model one time unit after each edge.
    always @(posedge clk_sys) begin
        #1;
        if (!reset && model_on) begin
            exp_t e;
            edge_n++;
            if (ce_p)   p_edges.push_back(edge_n);
            if (ce_n)   n_edges.push_back(edge_n);
            if (ce_psg) psg_edges.push_back(edge_n);
            if (exp_q.size() == 0) begin
                check_output("model_queue", 0, 1);
                push_period(m_mode, gaps_left == 0, 1'b0);
            end
            e = exp_q.pop_front();
            if (e.srun && m_stall_cnt < 65535) m_stall_cnt++;
            if (exp_q.size() == 0) plan_period();
            check_output("ce_p", int'(ce_p), int'(e.p));
            check_output("ce_n", int'(ce_n), int'(e.n));
            check_output("ce_psg", int'(ce_psg), int'(((edge_n - 1) % PSG_DIV) == 0));
            check_output("mode_cur", int'(mode_cur), m_mode);
            check_output("switching", int'(switching), int'(gaps_left != 0));
`ifdef CE_GEN_STALL_CNT_EN
            check_output("stall_cnt", int'(stall_cnt), m_stall_cnt);
`endif
        end
    end

    // Assert reset (at a negedge or mid-cycle), check the quiet outputs,
    // then release it at a negedge with the model restarted.
    task automatic apply_stimulus_reset(input bit mid_cycle);
        if (mid_cycle) begin
            @(posedge clk_sys);
            #3;
        end else begin
            @(negedge clk_sys);
        end
        model_on = 0;
        reset = 1'b1;
        #1;
        check_output("rst_ce_p", int'(ce_p), 0);
        check_output("rst_ce_n", int'(ce_n), 0);
        check_output("rst_ce_psg", int'(ce_psg), 0);
        check_output("rst_mode_cur", int'(mode_cur), 0);
        check_output("rst_switching", int'(switching), 0);
        repeat (2) @(negedge clk_sys);
        model_init();
        model_on = 1;
        reset = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        $display("[TB] cpu_ce_gen bench start");

        // Native mode: ce_p every 16, ce_n 8 later.
        mode = 2'd0; wait_req = 1'b0;
        apply_stimulus_reset(1'b0);
        run_edges(40);
        check_edge("m0_p0", p_edges, 0, 1);
        check_edge("m0_p1", p_edges, 1, 17);
        check_edge("m0_n0", n_edges, 0, 9);

        // Stall across one boundary suppresses exactly the next period.
        apply_stimulus_reset(1'b0);
        run_edges(4);
        wait_req = 1'b1;
        run_edges(12);
        wait_req = 1'b0;
        run_edges(30);
        check_edge("stall_p1", p_edges, 1, 33);
        check_edge("stall_n1", n_edges, 1, 41);
`ifdef CE_GEN_STALL_CNT_EN
        check_output("stall_cnt_lit", int'(stall_cnt), 1);
`endif

        // Mode 1 held from reset: switch at edge 16, 81-cycle gap.
        mode = 2'd1;
        apply_stimulus_reset(1'b0);
        run_edges(130);
        check_edge("m1_p0", p_edges, 0, 1);
        check_edge("m1_p1", p_edges, 1, 98);
        check_edge("m1_n1", n_edges, 1, 111);
        check_edge("m1_p2", p_edges, 2, 125);

        // Retarget during the gap toward mode 2: gap restarts in mode 1.
        mode = 2'd2;
        apply_stimulus_reset(1'b0);
        run_edges(18);
        mode = 2'd1;
        run_edges(130);
        check_edge("retgt_p1", p_edges, 1, 110);
        check_edge("retgt_p2", p_edges, 2, 137);

        // Mode 3 behaves as mode 0; 2 -> 3 lands in mode 0.
        mode = 2'd3;
        apply_stimulus_reset(1'b0);
        run_edges(20);
        check_edge("m3_p1", p_edges, 1, 17);
        mode = 2'd2;
        run_edges(60);
        mode = 2'd3;
        run_edges(40);
        check_output("m3_mode_cur", int'(mode_cur), 0);

        // Reset in the middle of a gap, then PSG restart positions.
        mode = 2'd1;
        apply_stimulus_reset(1'b0);
        run_edges(30);
        check_output("gap_switching", int'(switching), 1);
        mode = 2'd0;
        apply_stimulus_reset(1'b1);
        run_edges(30);
        check_edge("psg_0", psg_edges, 0, 1);
        check_edge("psg_1", psg_edges, 1, 13);
        check_edge("psg_2", psg_edges, 2, 25);

        // Randomized phase: rare mode changes, frequent stall requests.
        apply_stimulus_reset(1'b0);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_sys);
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            wait_req = ($urandom_range(0, 3) == 0);
        end
        run_edges(2);
        model_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
